// File: rtl/beta_csr_pkg.sv
// Shared types and constants for the machine-mode trap control unit:
// FSM states, cause codes, mtvec modes and the live CSR bundle.
package beta_csr_pkg;

  localparam int unsigned CsrWidth = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DRAIN    = 3'd1,
    ST_TRAP_WR  = 3'd2,
    ST_MRET_WR  = 3'd3,
    ST_REDIRECT = 3'd4
  } trap_fsm_e;

  // Interrupt codes (mcause[4:0] with mcause MSB set)
  localparam logic [4:0] IRQ_CODE_MSI = 5'd3;
  localparam logic [4:0] IRQ_CODE_MTI = 5'd7;
  localparam logic [4:0] IRQ_CODE_MEI = 5'd11;

  localparam logic [4:0] EXC_INSTR_MISALIGNED = 5'd0;
  localparam logic [4:0] EXC_ILLEGAL_INSTR    = 5'd2;
  localparam logic [4:0] EXC_BREAKPOINT       = 5'd3;
  localparam logic [4:0] EXC_LOAD_FAULT       = 5'd5;
  localparam logic [4:0] EXC_ECALL_M          = 5'd11;

  localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

  // Interrupt sources are {pending, enable}
  typedef struct packed {
    logic                mie;
    logic                mpie;
    logic [CsrWidth-1:0] mtvec;
    logic [CsrWidth-1:0] mepc;
    logic [CsrWidth-1:0] mcause;
    logic [CsrWidth-1:0] mtval;
    logic [1:0]          ext_int;
    logic [1:0]          tim_int;
    logic [1:0]          soft_int;
  } csr_ctrl_t;

endpackage

// File: rtl/beta_irq_prio.sv
// Combinational interrupt priority encoder: MEI > MSI > MTI, gated by mie.
module beta_irq_prio
  import beta_csr_pkg::*;
(
  input  logic       mie_i,
  input  logic [1:0] ext_int_i,
  input  logic [1:0] tim_int_i,
  input  logic [1:0] soft_int_i,
  output logic       eligible_o,
  output logic [4:0] code_o
);

  always_comb begin
    eligible_o = 1'b0;
    code_o     = '0;
    if (mie_i) begin
      if (ext_int_i == 2'b11) begin
        eligible_o = 1'b1;
        code_o     = IRQ_CODE_MEI;
      end else if (soft_int_i == 2'b11) begin
        eligible_o = 1'b1;
        code_o     = IRQ_CODE_MSI;
      end else if (tim_int_i == 2'b11) begin
        eligible_o = 1'b1;
        code_o     = IRQ_CODE_MTI;
      end
    end
  end

endmodule

// File: rtl/beta_trap_ctrl.sv
// Machine-mode trap control unit: arbitrates exceptions, MRET and interrupts,
// writes trap CSR state, flushes the pipeline and redirects fetch.
module beta_trap_ctrl
  import beta_csr_pkg::*;
#(
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 exc_valid_i,
  input  logic [4:0]           exc_cause_i,
  input  logic [DataWidth-1:0] exc_pc_i,
  input  logic [DataWidth-1:0] exc_tval_i,
  input  logic                 mret_i,
  input  logic [DataWidth-1:0] next_pc_i,
  input  logic                 pipe_idle_i,
  input  csr_ctrl_t            csr_control_i,
  output logic                 tcu_csr_we_o,
  output logic [DataWidth-1:0] csr_mcause_o,
  output logic [DataWidth-1:0] csr_mepc_o,
  output logic [DataWidth-1:0] csr_mtval_o,
  output logic [2:0]           csr_trap_state_o,
  output logic                 stall_o,
  output logic                 flush_o,
  output logic                 redirect_valid_o,
  output logic [DataWidth-1:0] redirect_pc_o,
  input  logic                 redirect_ready_i,
  output logic                 busy_o
);

  trap_fsm_e            state_q, state_d;
  logic [DataWidth-1:0] cause_q, cause_d;
  logic [DataWidth-1:0] epc_q, epc_d;
  logic [DataWidth-1:0] tval_q, tval_d;
  logic [DataWidth-1:0] target_q, target_d;
  logic                 irq_q, irq_d;
  logic                 we_q, we_d;
  logic                 flush_q, flush_d;
  logic                 stall_q, stall_d;
  logic                 rvalid_q, rvalid_d;
  logic [DataWidth-1:0] mcause_out_q, mcause_out_d;
  logic [DataWidth-1:0] mepc_out_q, mepc_out_d;
  logic [DataWidth-1:0] mtval_out_q, mtval_out_d;
  logic [2:0]           trap_st_q, trap_st_d;

  logic                 irq_eligible;
  logic [4:0]           irq_code;
  logic [DataWidth-1:0] irq_cause, exc_cause;
  logic [DataWidth-1:0] mtvec_w, mtvec_base, trap_target;

  beta_irq_prio u_irq_prio (
    .mie_i      (csr_control_i.mie),
    .ext_int_i  (csr_control_i.ext_int),
    .tim_int_i  (csr_control_i.tim_int),
    .soft_int_i (csr_control_i.soft_int),
    .eligible_o (irq_eligible),
    .code_o     (irq_code)
  );

  assign irq_cause  = {1'b1, {(DataWidth-6){1'b0}}, irq_code};
  assign exc_cause  = {{(DataWidth-5){1'b0}}, exc_cause_i};
  assign mtvec_w    = DataWidth'(csr_control_i.mtvec);
  assign mtvec_base = {mtvec_w[DataWidth-1:2], 2'b00};

  // Vectored mode only applies to interrupts; the add wraps naturally.
  assign trap_target = (irq_q && (mtvec_w[1:0] == MTVEC_MODE_VECTORED))
                     ? mtvec_base + DataWidth'({cause_q[4:0], 2'b00})
                     : mtvec_base;

  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    epc_d        = epc_q;
    tval_d       = tval_q;
    target_d     = '0;
    irq_d        = irq_q;
    we_d         = 1'b0;
    flush_d      = 1'b0;
    stall_d      = 1'b0;
    rvalid_d     = 1'b0;
    mcause_out_d = '0;
    mepc_out_d   = '0;
    mtval_out_d  = '0;
    trap_st_d    = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (exc_valid_i) begin
          cause_d      = exc_cause;
          epc_d        = exc_pc_i;
          tval_d       = exc_tval_i;
          irq_d        = 1'b0;
          state_d      = ST_TRAP_WR;
          we_d         = 1'b1;
          flush_d      = 1'b1;
          mcause_out_d = exc_cause;
          mepc_out_d   = exc_pc_i;
          mtval_out_d  = exc_tval_i;
          trap_st_d    = {1'b0, csr_control_i.mie, 1'b1};
        end else if (mret_i) begin
          state_d      = ST_MRET_WR;
          we_d         = 1'b1;
          flush_d      = 1'b1;
          mcause_out_d = DataWidth'(csr_control_i.mcause);
          mepc_out_d   = DataWidth'(csr_control_i.mepc);
          mtval_out_d  = DataWidth'(csr_control_i.mtval);
          trap_st_d    = {csr_control_i.mpie, 1'b1, 1'b0};
        end else if (irq_eligible) begin
          cause_d = irq_cause;
          tval_d  = '0;
          irq_d   = 1'b1;
          state_d = ST_DRAIN;
          stall_d = 1'b1;
        end
      end

      // The interrupt is already latched, so withdrawal here has no effect.
      ST_DRAIN: begin
        stall_d = 1'b1;
        if (pipe_idle_i) begin
          epc_d        = next_pc_i;
          state_d      = ST_TRAP_WR;
          stall_d      = 1'b0;
          we_d         = 1'b1;
          flush_d      = 1'b1;
          mcause_out_d = cause_q;
          mepc_out_d   = next_pc_i;
          mtval_out_d  = tval_q;
          trap_st_d    = {1'b0, csr_control_i.mie, 1'b1};
        end
      end

      ST_TRAP_WR: begin
        state_d  = ST_REDIRECT;
        rvalid_d = 1'b1;
        target_d = trap_target;
      end

      ST_MRET_WR: begin
        state_d  = ST_REDIRECT;
        rvalid_d = 1'b1;
        target_d = DataWidth'(csr_control_i.mepc);
      end

      ST_REDIRECT: begin
        if (redirect_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          rvalid_d = 1'b1;
          target_d = target_q;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q      <= ST_IDLE;
      cause_q      <= '0;
      epc_q        <= '0;
      tval_q       <= '0;
      target_q     <= '0;
      irq_q        <= 1'b0;
      we_q         <= 1'b0;
      flush_q      <= 1'b0;
      stall_q      <= 1'b0;
      rvalid_q     <= 1'b0;
      mcause_out_q <= '0;
      mepc_out_q   <= '0;
      mtval_out_q  <= '0;
      trap_st_q    <= '0;
    end else begin
      state_q      <= state_d;
      cause_q      <= cause_d;
      epc_q        <= epc_d;
      tval_q       <= tval_d;
      target_q     <= target_d;
      irq_q        <= irq_d;
      we_q         <= we_d;
      flush_q      <= flush_d;
      stall_q      <= stall_d;
      rvalid_q     <= rvalid_d;
      mcause_out_q <= mcause_out_d;
      mepc_out_q   <= mepc_out_d;
      mtval_out_q  <= mtval_out_d;
      trap_st_q    <= trap_st_d;
    end
  end

  assign tcu_csr_we_o     = we_q;
  assign flush_o          = flush_q;
  assign stall_o          = stall_q;
  assign csr_mcause_o     = mcause_out_q;
  assign csr_mepc_o       = mepc_out_q;
  assign csr_mtval_o      = mtval_out_q;
  assign csr_trap_state_o = trap_st_q;
  assign redirect_valid_o = rvalid_q;
  assign redirect_pc_o    = target_q;
  assign busy_o           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_beta_trap_ctrl.sv
// Scoreboard bench for beta_trap_ctrl: a request-level reference model queues
// expected CSR writes and redirect targets; a monitor pops and compares them.
module tb_beta_trap_ctrl;
  import beta_csr_pkg::*;

  logic        clk = 1'b0;
  logic        rstn_i = 1'b0;
  logic        exc_valid_i = 1'b0;
  logic [4:0]  exc_cause_i = '0;
  logic [31:0] exc_pc_i = '0;
  logic [31:0] exc_tval_i = '0;
  logic        mret_i = 1'b0;
  logic [31:0] next_pc_i = '0;
  logic        pipe_idle_i = 1'b0;
  csr_ctrl_t   csr_control_i = '0;
  logic        redirect_ready_i = 1'b0;
  logic        tcu_csr_we_o, stall_o, flush_o, redirect_valid_o, busy_o;
  logic [31:0] csr_mcause_o, csr_mepc_o, csr_mtval_o, redirect_pc_o;
  logic [2:0]  csr_trap_state_o;

  always #5 clk = ~clk;

  beta_trap_ctrl #(.DataWidth(32)) dut (
    .clk_i            (clk),
    .rstn_i           (rstn_i),
    .exc_valid_i      (exc_valid_i),
    .exc_cause_i      (exc_cause_i),
    .exc_pc_i         (exc_pc_i),
    .exc_tval_i       (exc_tval_i),
    .mret_i           (mret_i),
    .next_pc_i        (next_pc_i),
    .pipe_idle_i      (pipe_idle_i),
    .csr_control_i    (csr_control_i),
    .tcu_csr_we_o     (tcu_csr_we_o),
    .csr_mcause_o     (csr_mcause_o),
    .csr_mepc_o       (csr_mepc_o),
    .csr_mtval_o      (csr_mtval_o),
    .csr_trap_state_o (csr_trap_state_o),
    .stall_o          (stall_o),
    .flush_o          (flush_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .redirect_ready_i (redirect_ready_i),
    .busy_o           (busy_o)
  );

  typedef struct packed {
    logic [31:0] mcause;
    logic [31:0] mepc;
    logic [31:0] mtval;
    logic [2:0]  st;
  } wr_t;

  wr_t         wr_q[$];
  logic [31:0] rd_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic        force_ready_low = 1'b0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic report_fail(input string msg);
    vectors++;
    miscompares++;
    $display("FAIL %s", msg);
  endtask

  // Reference model: eligible interrupt code, or -1 when none qualifies.
  function automatic int irq_code(input csr_ctrl_t c);
    if (!c.mie) return -1;
    if (c.ext_int == 2'b11) return 11;
    if (c.soft_int == 2'b11) return 3;
    if (c.tim_int == 2'b11) return 7;
    return -1;
  endfunction

  function automatic logic [31:0] trap_target(input csr_ctrl_t c, input logic is_irq,
                                              input logic [31:0] cause);
    logic [31:0] base;
    base = c.mtvec & 32'hFFFF_FFFC;
    if (is_irq && c.mtvec[1:0] == 2'b01) return base + 32'd4 * (cause & 32'd31);
    return base;
  endfunction

  function automatic logic [159:0] all_outputs();
    return 160'({tcu_csr_we_o, csr_mcause_o, csr_mepc_o, csr_mtval_o, csr_trap_state_o,
                 stall_o, flush_o, redirect_valid_o, redirect_pc_o, busy_o});
  endfunction

  // Fetch-side and pipeline-side random responders
  initial begin
    forever begin
      @(posedge clk);
      #1;
      redirect_ready_i = force_ready_low ? 1'b0 : ($urandom_range(0, 2) == 0);
      pipe_idle_i      = ($urandom_range(0, 3) == 0);
    end
  end

  // Monitor
  wr_t         mon_wr;
  logic [31:0] mon_pc;
  logic        prev_rv = 1'b0, prev_rdy = 1'b0, prev_rstn = 1'b0;
  logic [31:0] prev_pc = '0;

  always @(negedge clk) begin
    if (tcu_csr_we_o) begin
      check("flush_with_we", 160'(flush_o), 160'(1'b1));
      if (wr_q.size() == 0) report_fail("unexpected_csr_write: tcu_csr_we_o=1, none expected");
      else begin
        mon_wr = wr_q.pop_front();
        check("csr_write", 160'({csr_mcause_o, csr_mepc_o, csr_mtval_o, csr_trap_state_o}),
              160'(mon_wr));
      end
    end else if (flush_o) begin
      report_fail("stray_flush: flush_o=1 while tcu_csr_we_o=0");
    end
    if (stall_o && (!busy_o || tcu_csr_we_o)) report_fail("stray_stall: stall_o=1 outside drain");
    if (redirect_valid_o && redirect_ready_i) begin
      if (rd_q.size() == 0) report_fail("unexpected_redirect: handshake with none expected");
      else begin
        mon_pc = rd_q.pop_front();
        check("redirect_pc", 160'(redirect_pc_o), 160'(mon_pc));
      end
    end
    if (prev_rv && !prev_rdy && prev_rstn)
      check("redirect_stable", 160'({redirect_valid_o, redirect_pc_o}), 160'({1'b1, prev_pc}));
    prev_rv   = redirect_valid_o;
    prev_rdy  = redirect_ready_i;
    prev_rstn = rstn_i;
    prev_pc   = redirect_pc_o;
  end

  task automatic wait_busy(input logic lvl, input int budget, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy_o !== lvl && n < budget);
    if (busy_o !== lvl) report_fail($sformatf("%s: busy_o=%0b after %0d cycles, required %0b",
                                              name, busy_o, n, lvl));
  endtask

  // Present a set of simultaneous requests; the model serves them one at a
  // time in priority order, dropping each once the controller has taken it.
  task automatic run_txn(input csr_ctrl_t c_in, input logic ex, input logic [4:0] ec,
                         input logic [31:0] epc, input logic [31:0] tval,
                         input logic [31:0] npc, input logic mr);
    csr_ctrl_t   c;
    int          code;
    int          served;
    logic [31:0] cause;
    c = c_in;
    served = 0;
    @(posedge clk);
    #1;
    csr_control_i = c;
    exc_valid_i   = ex;
    exc_cause_i   = ec;
    exc_pc_i      = epc;
    exc_tval_i    = tval;
    mret_i        = mr;
    next_pc_i     = npc;
    for (int k = 0; k < 4; k++) begin
      code = irq_code(c);
      if (exc_valid_i) begin
        wr_q.push_back({32'(ec), epc, tval, 1'b0, c.mie, 1'b1});
        rd_q.push_back(trap_target(c, 1'b0, 32'(ec)));
      end else if (mret_i) begin
        wr_q.push_back({c.mcause, c.mepc, c.mtval, c.mpie, 2'b10});
        rd_q.push_back(c.mepc);
      end else if (code >= 0) begin
        cause = 32'h8000_0000 | 32'(code);
        wr_q.push_back({cause, npc, 32'd0, 3'b011});
        rd_q.push_back(trap_target(c, 1'b1, cause));
      end else break;
      wait_busy(1'b1, 4, "accept_timeout");
      @(posedge clk);
      #1;
      if (exc_valid_i) exc_valid_i = 1'b0;
      else if (mret_i) mret_i = 1'b0;
      else if (code == 11) c.ext_int[1] = 1'b0;
      else if (code == 3) c.soft_int[1] = 1'b0;
      else c.tim_int[1] = 1'b0;
      csr_control_i = c;
      served++;
      wait_busy(1'b0, 300, "complete_timeout");
    end
    if (served == 0) begin
      repeat (3) begin
        @(negedge clk);
        check("no_request_busy", 160'(busy_o), 160'(1'b0));
      end
    end
  endtask

  csr_ctrl_t   c;
  logic [31:0] exp_pc;
  int          n;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outputs(), '0);
    @(posedge clk);
    #1;
    rstn_i = 1'b1;

    // Exception, direct mode
    c = '0;
    c.mie = 1'b1;
    c.mtvec = 32'h0000_1000;
    run_txn(c, 1'b1, EXC_ILLEGAL_INSTR, 32'h100, 32'hDEAD, 32'h0, 1'b0);

    // MEI beats MTI, vectored mode; MTI follows
    c = '0;
    c.mie = 1'b1;
    c.mtvec = 32'h0000_1001;
    c.ext_int = 2'b11;
    c.tim_int = 2'b11;
    run_txn(c, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0000_0400, 1'b0);

    // Exception, MRET and interrupt together
    c = '0;
    c.mie = 1'b1;
    c.mpie = 1'b1;
    c.mtvec = 32'h0000_2001;
    c.mepc = 32'h0000_0300;
    c.mcause = 32'h8000_0007;
    c.mtval = 32'h1234;
    c.soft_int = 2'b11;
    run_txn(c, 1'b1, EXC_ECALL_M, 32'h0000_0880, 32'h0, 32'h0000_0884, 1'b1);

    // MRET alone
    c = '0;
    c.mpie = 1'b1;
    c.mepc = 32'h0000_0200;
    c.mtvec = 32'h0000_1000;
    run_txn(c, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1);

    // Interrupts masked by mie
    c = '0;
    c.ext_int = 2'b11;
    c.tim_int = 2'b11;
    c.mtvec = 32'h0000_1000;
    run_txn(c, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);

    // Vectored target wraps past the top of the address space
    c = '0;
    c.mie = 1'b1;
    c.mtvec = 32'hFFFF_FFE1;
    c.ext_int = 2'b11;
    run_txn(c, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0000_0010, 1'b0);

    // Redirect held off, then reset in the middle of it
    force_ready_low = 1'b1;
    c = '0;
    c.mie = 1'b1;
    c.mtvec = 32'h0000_4000;
    exp_pc = trap_target(c, 1'b0, 32'd5);
    wr_q.push_back({32'd5, 32'h0000_0044, 32'h0000_BEEF, 3'b011});
    @(posedge clk);
    #1;
    csr_control_i = c;
    exc_valid_i = 1'b1;
    exc_cause_i = EXC_LOAD_FAULT;
    exc_pc_i = 32'h0000_0044;
    exc_tval_i = 32'h0000_BEEF;
    wait_busy(1'b1, 4, "accept_timeout");
    @(posedge clk);
    #1;
    exc_valid_i = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!redirect_valid_o && n < 10);
    repeat (5) begin
      check("redirect_hold", 160'({redirect_valid_o, redirect_pc_o}), 160'({1'b1, exp_pc}));
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rstn_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_mid_redirect", all_outputs(), '0);
    @(negedge clk);
    check("reset_held", all_outputs(), '0);
    @(posedge clk);
    #1;
    rstn_i = 1'b1;
    force_ready_low = 1'b0;
    @(negedge clk);
    check("after_reset_idle", all_outputs(), '0);

    // Randomized request mixes
    for (int t = 0; t < 60; t++) begin
      c = '0;
      c.mie      = 1'($urandom_range(0, 1));
      c.mpie     = 1'($urandom_range(0, 1));
      c.mtvec    = {$urandom_range(0, 32'hFFFF) , 14'($urandom_range(0, 16383)), 2'b00};
      c.mtvec[1:0] = 2'($urandom_range(0, 1));
      c.mepc     = $urandom() & 32'hFFFF_FFFC;
      c.mcause   = $urandom();
      c.mtval    = $urandom();
      c.ext_int  = 2'($urandom_range(0, 3));
      c.tim_int  = 2'($urandom_range(0, 3));
      c.soft_int = 2'($urandom_range(0, 3));
      run_txn(c, ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 15)), $urandom(),
              $urandom(), $urandom() & 32'hFFFF_FFFC, ($urandom_range(0, 3) == 0));
    end

    repeat (4) @(negedge clk);
    check("queues_drained", 160'(wr_q.size() + rd_q.size()), 160'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
